// File: rtl/clock_counter_mc_if.sv
`default_nettype none
// ============================================================================
// clock_counter_mc_if : Avalon-MM control bus between a host and clock_counter_mc
// Revision 2.0
// ============================================================================
interface clock_counter_mc_if;
  logic [8:0]  avs_ctrl_address;
  logic        avs_ctrl_read;
  logic        avs_ctrl_write;
  logic [31:0] avs_ctrl_readdata;
  logic [31:0] avs_ctrl_writedata;

  modport master (
    output avs_ctrl_address,
    output avs_ctrl_read,
    output avs_ctrl_write,
    output avs_ctrl_writedata,
    input  avs_ctrl_readdata
  );

  modport slave (
    input  avs_ctrl_address,
    input  avs_ctrl_read,
    input  avs_ctrl_write,
    input  avs_ctrl_writedata,
    output avs_ctrl_readdata
  );
endinterface
`default_nettype wire

// File: rtl/clock_counter_mc.sv
`default_nettype none
// ============================================================================
// clock_counter_mc : multi-channel clock frequency meter with Avalon-MM control
// Optional per-channel MIN/MAX tracking: define CLOCK_COUNTER_MC_MINMAX_EN
// Revision 2.0
// ============================================================================
module clock_counter_mc #(
  parameter int NR_CH       = 8,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 3
) (
  input wire               csi_clk_clk,
  input wire               rsi_reset_reset,
  clock_counter_mc_if.slave avs_ctrl,
  input wire [NR_CH-1:0]   coe_meas
);

  localparam logic [31:0] ID_VALUE      = 32'hc10cc272;
  localparam logic [31:0] VERSION_VALUE = 32'h00020000;
  localparam logic [31:0] BAD_VALUE     = 32'hdeadbeef;
`ifdef CLOCK_COUNTER_MC_MINMAX_EN
  localparam logic        MINMAX_PRESENT = 1'b1;
`else
  localparam logic        MINMAX_PRESENT = 1'b0;
`endif
  localparam logic [31:0] CONFIG_VALUE  =
    {20'd0, 3'(SYNC_STAGES), MINMAX_PRESENT, 8'(NR_CH)};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       scratch;
  logic              enable;
  logic              single_shot;
  logic [GATE_W-1:0] gate;
  logic [GATE_W-1:0] gate_cnt;
  logic [15:0]       update_cnt;
  logic [CNT_W-1:0]  result   [NR_CH];
  logic [CNT_W-1:0]  acc      [NR_CH];
  logic [CNT_W-1:0]  acc_next [NR_CH];
`ifdef CLOCK_COUNTER_MC_MINMAX_EN
  logic [CNT_W-1:0]  min_val  [NR_CH];
  logic [CNT_W-1:0]  max_val  [NR_CH];
`endif

  logic [NR_CH-1:0]  sync_chain [SYNC_STAGES];
  logic [NR_CH-1:0]  edge_hist;
  logic [NR_CH-1:0]  meas_edge;

  logic [8:0]        addr;
  logic [31:0]       wdata;
  logic              wr;
  logic              wr_scratch;
  logic              wr_control;
  logic              wr_gate;
  logic              clear_pulse;
  logic              enable_next;
  logic [31:0]       rd_mux;
  logic              unused_read;

  assign addr        = avs_ctrl.avs_ctrl_address;
  assign wdata       = avs_ctrl.avs_ctrl_writedata;
  assign wr          = avs_ctrl.avs_ctrl_write;
  assign unused_read = avs_ctrl.avs_ctrl_read;

  assign wr_scratch  = wr && (addr == 9'h003);
  assign wr_control  = wr && (addr == 9'h004);
  assign wr_gate     = wr && (addr == 9'h005);
  assign clear_pulse = wr_control && wdata[2];
  // Disabling takes effect in the same cycle the CONTROL write lands.
  assign enable_next = wr_control ? wdata[0] : enable;

  always_ff @(posedge csi_clk_clk) begin
    if (rsi_reset_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
      edge_hist <= '0;
    end else begin
      sync_chain[0] <= coe_meas;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
      edge_hist <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign meas_edge = sync_chain[SYNC_STAGES-1] & ~edge_hist;

  // Saturating per-channel increment, shared by RUN accumulation and window close.
  for (genvar g = 0; g < NR_CH; g++) begin : g_chan
    assign acc_next[g] = (meas_edge[g] && !(&acc[g])) ? acc[g] + CNT_W'(1) : acc[g];
  end

  always_ff @(posedge csi_clk_clk) begin
    if (rsi_reset_reset) begin
      state       <= ST_IDLE;
      scratch     <= '0;
      enable      <= 1'b0;
      single_shot <= 1'b0;
      gate        <= '0;
      gate_cnt    <= '0;
      update_cnt  <= '0;
      for (int ch = 0; ch < NR_CH; ch++) begin
        result[ch] <= '0;
        acc[ch]    <= '0;
`ifdef CLOCK_COUNTER_MC_MINMAX_EN
        min_val[ch] <= '1;
        max_val[ch] <= '0;
`endif
      end
    end else begin
      if (wr_scratch) scratch <= wdata;
      if (wr_control) begin
        enable      <= wdata[0];
        single_shot <= wdata[1];
      end
      if (wr_gate) gate <= wdata[GATE_W-1:0];

      case (state)
        ST_IDLE: begin
          if (enable && gate != '0) state <= ST_ARM;
        end
        ST_ARM: begin
          for (int ch = 0; ch < NR_CH; ch++) acc[ch] <= '0;
          gate_cnt <= gate;
          state    <= (enable_next && gate != '0) ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (!enable_next) begin
            for (int ch = 0; ch < NR_CH; ch++) acc[ch] <= '0;
            state <= ST_IDLE;
          end else if (clear_pulse) begin
            state <= ST_ARM;
          end else if (gate_cnt == GATE_W'(1)) begin
            for (int ch = 0; ch < NR_CH; ch++) begin
              result[ch] <= acc_next[ch];
              acc[ch]    <= '0;
`ifdef CLOCK_COUNTER_MC_MINMAX_EN
              if (acc_next[ch] < min_val[ch]) min_val[ch] <= acc_next[ch];
              if (acc_next[ch] > max_val[ch]) max_val[ch] <= acc_next[ch];
`endif
            end
            update_cnt <= update_cnt + 16'd1;
            if (single_shot) begin
              enable <= 1'b0;
              state  <= ST_IDLE;
            end else if (gate == '0) begin
              state <= ST_IDLE;
            end else begin
              gate_cnt <= gate;
            end
          end else begin
            for (int ch = 0; ch < NR_CH; ch++) acc[ch] <= acc_next[ch];
            gate_cnt <= gate_cnt - GATE_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed last so a clear overrides a window completing in the same cycle.
      if (clear_pulse) begin
        update_cnt <= '0;
        for (int ch = 0; ch < NR_CH; ch++) begin
          result[ch] <= '0;
`ifdef CLOCK_COUNTER_MC_MINMAX_EN
          min_val[ch] <= '1;
          max_val[ch] <= '0;
`endif
        end
      end
    end
  end

  always_comb begin
    rd_mux = BAD_VALUE;
    case (addr)
      9'h000:  rd_mux = ID_VALUE;
      9'h001:  rd_mux = VERSION_VALUE;
      9'h002:  rd_mux = CONFIG_VALUE;
      9'h003:  rd_mux = scratch;
      9'h004:  rd_mux = {30'd0, single_shot, enable};
      9'h005:  rd_mux = 32'(gate);
      9'h006:  rd_mux = {(state != ST_IDLE), 15'd0, update_cnt};
      default: rd_mux = BAD_VALUE;
    endcase
    for (int ch = 0; ch < NR_CH; ch++) begin
      if (addr == 9'(16 + ch)) rd_mux = 32'(result[ch]);
`ifdef CLOCK_COUNTER_MC_MINMAX_EN
      if (addr == 9'(48 + ch)) rd_mux = 32'(min_val[ch]);
      if (addr == 9'(80 + ch)) rd_mux = 32'(max_val[ch]);
`endif
    end
  end

  always_ff @(posedge csi_clk_clk) begin
    if (rsi_reset_reset) avs_ctrl.avs_ctrl_readdata <= '0;
    else                 avs_ctrl.avs_ctrl_readdata <= rd_mux;
  end

endmodule
`default_nettype wire
